// File: rtl/mcdt_arb.sv
// mcdt_arb: multi-channel transmitter, per-channel FIFOs merged onto one tagged output stream
// Ports: clk; rstn (async, active-high reset); ch_data_i/ch_valid_i/ch_ready_o per-channel write side;
//        ch_en_i channel enables; ch_margin_o free entries per channel; ch_ovf_o/ovf_clr_i sticky overflow;
//        arb_mode_i 0=fixed priority, 1=round-robin; mcdt_data_o/mcdt_val_o/mcdt_id_o/mcdt_ready_i output stream.
// Define MCDT_OVF_EN to build the sticky overflow flags; otherwise ch_ovf_o is tied to 0.
module mcdt_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH = 16,
    localparam int ID_W = $clog2(NUM_CH),
    localparam int MW = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    output logic [NUM_CH-1:0]        ch_ready_o,
    input  logic [NUM_CH-1:0]        ch_en_i,
    output logic [NUM_CH*MW-1:0]     ch_margin_o,
    output logic [NUM_CH-1:0]        ch_ovf_o,
    input  logic                     ovf_clr_i,
    input  logic                     arb_mode_i,
    output logic [DATA_W-1:0]        mcdt_data_o,
    output logic                     mcdt_val_o,
    output logic [ID_W-1:0]          mcdt_id_o,
    input  logic                     mcdt_ready_i
);
    localparam int AW = $clog2(DEPTH);
    logic [NUM_CH-1:0] full, elig, wr, pop;
    logic [NUM_CH*DATA_W-1:0] rd_all;
    logic [ID_W-1:0] gnt, last, idx;
    logic any, free;
    assign free = ~mcdt_val_o | mcdt_ready_i;
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0] rptr, wptr;
        logic [MW-1:0] cnt;
        assign full[k] = cnt == MW'(DEPTH);
        assign elig[k] = ch_en_i[k] & (cnt != '0);
        assign ch_ready_o[k] = ch_en_i[k] & ~full[k];
        assign wr[k] = ch_valid_i[k] & ch_ready_o[k];
        assign pop[k] = free & any & (gnt == ID_W'(k));
        assign ch_margin_o[k*MW +: MW] = MW'(DEPTH) - cnt;
        assign rd_all[k*DATA_W +: DATA_W] = mem[rptr];
        always_ff @(posedge clk or posedge rstn) begin
            if (rstn) begin
                rptr <= '0;
                wptr <= '0;
                cnt <= '0;
            end else begin
                if (wr[k]) wptr <= wptr + 1'b1;
                if (pop[k]) rptr <= rptr + 1'b1;
                cnt <= cnt + MW'(wr[k]) - MW'(pop[k]);
            end
        end
        always_ff @(posedge clk) begin
            if (wr[k]) mem[wptr] <= ch_data_i[k*DATA_W +: DATA_W];
        end
    end
    // Scan order: plain index in fixed mode, rotated past last grant in round-robin.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ID_W'(arb_mode_i ? (int'(last) + 1 + i) % NUM_CH : i);
            if (!any && elig[idx]) begin
                any = 1'b1;
                gnt = idx;
            end
        end
    end
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mcdt_data_o <= '0;
            mcdt_id_o <= '0;
            mcdt_val_o <= 1'b0;
            last <= ID_W'(NUM_CH - 1);
        end else if (free) begin
            mcdt_val_o <= any;
            if (any) begin
                mcdt_data_o <= rd_all[int'(gnt)*DATA_W +: DATA_W];
                mcdt_id_o <= gnt;
                last <= gnt;
            end
        end
    end
`ifdef MCDT_OVF_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) ch_ovf_o <= '0;
        else if (ovf_clr_i) ch_ovf_o <= '0;
        else ch_ovf_o <= ch_ovf_o | (ch_valid_i & ch_en_i & full);
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign ch_ovf_o = '0;
`endif
endmodule

// File: tb/tb_mcdt_arb.sv
// tb_mcdt_arb: directed self-checking bench for mcdt_arb (NUM_CH=4, DATA_W=32, DEPTH=16)
module tb_mcdt_arb;
`ifdef MCDT_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif
    logic clk = 1'b0, rstn = 1'b1;
    logic [127:0] ch_data = '0;
    logic [3:0] ch_valid = '0, ch_ready, ch_en = 4'hF, ch_ovf;
    logic [19:0] ch_margin;
    logic ovf_clr = 1'b0, arb_mode = 1'b0, mcdt_val, mcdt_ready = 1'b0;
    logic [31:0] mcdt_data;
    logic [1:0] mcdt_id;
    int errs = 0, checks = 0;
    logic [31:0] exp_d[$];
    logic [1:0] exp_id[$];

    mcdt_arb dut (
        .clk(clk), .rstn(rstn), .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_en_i(ch_en), .ch_margin_o(ch_margin), .ch_ovf_o(ch_ovf), .ovf_clr_i(ovf_clr),
        .arb_mode_i(arb_mode), .mcdt_data_o(mcdt_data), .mcdt_val_o(mcdt_val), .mcdt_id_o(mcdt_id),
        .mcdt_ready_i(mcdt_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] mg(input int k);
        return ch_margin[k*5 +: 5];
    endfunction

    task automatic put(input int k, input logic [31:0] d);
        ch_data[k*32 +: 32] = d;
        ch_valid[k] = 1'b1;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        ch_valid = '0;
        ch_en = 4'hF;
        ovf_clr = 1'b0;
        mcdt_ready = 1'b0;
        exp_d.delete();
        exp_id.delete();
        tick();
        rstn = 1'b0;
        tick();
    endtask

    task automatic take(input string tag);
        if (mcdt_val && mcdt_ready) begin
            if (exp_d.size() == 0) chk({tag, " extra"}, {mcdt_id, mcdt_data}, 0);
            else begin
                chk({tag, " data"}, mcdt_data, exp_d.pop_front());
                chk({tag, " id"}, mcdt_id, exp_id.pop_front());
            end
        end
    endtask

    task automatic drain(input string tag, input int cycles);
        mcdt_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            take(tag);
            tick();
        end
        chk({tag, " left"}, exp_d.size(), 0);
    endtask

    task automatic preload();
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) put(k, k * 256 + j);
            tick();
        end
        ch_valid = '0;
    endtask

    initial begin
        // reset values while rstn held
        tick();
        chk("rst ready", ch_ready, 4'hF);
        chk("rst margin", ch_margin, {4{5'd16}});
        chk("rst ovf", ch_ovf, 0);
        chk("rst out", {mcdt_val, mcdt_id, mcdt_data}, 0);
        rstn = 1'b0;
        tick();
        // latency: written at edge t, valid after edge t+1
        put(0, 32'h55);
        tick();
        ch_valid = '0;
        chk("lat t", mcdt_val, 0);
        tick();
        chk("lat t+1", {mcdt_val, mcdt_id, mcdt_data}, {1'b1, 2'd0, 32'h55});

        // per-channel streams
        for (int k = 0; k < 4; k++) begin
            do_reset();
            mcdt_ready = 1'b1;
            for (int j = 0; j < 100; j++) begin
                exp_d.push_back(k * 4096 + j);
                exp_id.push_back(2'(k));
            end
            for (int j = 0; j < 104; j++) begin
                ch_valid = '0;
                if (j < 100) put(k, k * 4096 + j);
                take("stream");
                tick();
            end
            chk("stream left", exp_d.size(), 0);
            chk("stream margin", mg(k), 16);
        end

        // fixed-priority contention
        do_reset();
        arb_mode = 1'b0;
        preload();
        for (int i = 0; i < 16; i++) begin
            exp_id.push_back(2'(i / 4));
            exp_d.push_back((i / 4) * 256 + i % 4);
        end
        drain("fixed", 20);

        // round-robin contention
        do_reset();
        arb_mode = 1'b1;
        preload();
        for (int i = 0; i < 16; i++) begin
            exp_id.push_back(2'(i % 4));
            exp_d.push_back((i % 4) * 256 + i / 4);
        end
        drain("rr", 20);
        arb_mode = 1'b0;

        // backpressure: one word sits in the output register, 16 fill the FIFO, the 18th is refused
        do_reset();
        for (int j = 0; j < 18; j++) begin
            put(2, 32'h2000 + j);
            tick();
            if (j == 15) chk("bp margin16", mg(2), 1);
        end
        chk("bp margin", mg(2), 0);
        chk("bp ready", ch_ready[2], 0);
        chk("bp hold", {mcdt_val, mcdt_id, mcdt_data}, {1'b1, 2'd2, 32'h2000});
        chk("bp ovf", ch_ovf, {1'b0, OVF, 2'b00});
        ovf_clr = 1'b1;
        tick();
        chk("ovf clr prio", ch_ovf, 0);
        ovf_clr = 1'b0;
        ch_valid = '0;
        tick();
        chk("ovf stays clr", ch_ovf, 0);
        for (int j = 0; j < 17; j++) begin
            exp_d.push_back(32'h2000 + j);
            exp_id.push_back(2'd2);
        end
        drain("bp", 20);
        chk("bp margin end", mg(2), 16);

        // disable: ch1 holds 3 words while ch0 occupies the stalled output
        do_reset();
        put(0, 32'h0AAA);
        tick();
        ch_valid = '0;
        tick();
        for (int j = 0; j < 3; j++) begin
            put(1, 32'h1000 + j);
            tick();
        end
        ch_valid = '0;
        ch_en = 4'b1101;
        tick();
        chk("dis ready", ch_ready, 4'b1101);
        chk("dis margin", mg(1), 13);
        exp_d = '{32'h0AAA, 32'h3000, 32'h3001};
        exp_id = '{2'd0, 2'd3, 2'd3};
        mcdt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ch_valid = '0;
            if (i < 2) put(3, 32'h3000 + i);
            take("dis");
            tick();
        end
        ch_valid = '0;
        chk("dis left", exp_d.size(), 0);
        chk("dis margin kept", mg(1), 13);
        ch_en = 4'hF;
        exp_d = '{32'h1000, 32'h1001, 32'h1002};
        exp_id = '{2'd1, 2'd1, 2'd1};
        drain("reen", 6);
        chk("reen margin", mg(1), 16);

        // asynchronous reset mid-stream
        mcdt_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            put(0, 32'h7000 + j);
            tick();
        end
        ch_valid = '0;
        chk("pre-rst val", mcdt_val, 1);
        #2 rstn = 1'b1;
        #1;
        chk("async rst val", mcdt_val, 0);
        chk("async rst margin", ch_margin, {4{5'd16}});
        chk("async rst data", mcdt_data, 0);
        tick();
        rstn = 1'b0;
        tick();
        chk("post-rst val", mcdt_val, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
